// File: rtl/dly_tap_controller.sv
// -----------------------------------------------------------------------------
// dly_tap_controller
//
// Command-driven sequencer for a bank of delay elements and the tap-value mux
// that reads them back. One command (READ / INC / DEC / SET) is accepted at a
// time. The controller selects the element on the mux, samples its tap value,
// issues single-cycle adjust pulses as needed and returns the final sampled
// tap on a response handshake.
//
// Ports:
//   CLK            clock, all logic on the rising edge
//   RST            synchronous active-low reset
//   CMD_VALID/READY/OP/ADDR/TAP   command handshake and payload
//                                 (OP: 00 READ, 01 INC, 10 DEC, 11 SET)
//   RSP_VALID/READY/TAP/ERR       response handshake and payload
//   DLY_ADDR       registered select to the tap-value mux
//   DLY_TAP_VALUE  mux output (combinational from DLY_ADDR)
//   DLY_ADJ        one-hot adjust pulse, one bit per element
//   DLY_INCDEC     direction per element (1 = increment), only with DLY_ADJ
//   BUSY           high whenever a command is in progress
// -----------------------------------------------------------------------------
module dly_tap_controller #(
  parameter int NUM_DLY       = 20,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [1:0]         CMD_OP,
  input  logic [4:0]         CMD_ADDR,
  input  logic [5:0]         CMD_TAP,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [5:0]         RSP_TAP,
  output logic               RSP_ERR,
  output logic [4:0]         DLY_ADDR,
  input  logic [5:0]         DLY_TAP_VALUE,
  output logic [NUM_DLY-1:0] DLY_ADJ,
  output logic [NUM_DLY-1:0] DLY_INCDEC,
  output logic               BUSY
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  // 6 bits so that NUM_DLY = 32 is representable in the range check.
  localparam logic [5:0] NUM_DLY_W = 6'(NUM_DLY);

  localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [6:0]      MAX_STEPS   = 7'd64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SAMPLE,
    ST_PULSE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  state_t        state_reg,  state_next;
  logic [1:0]    op_reg,     op_next;
  logic [4:0]    addr_reg,   addr_next;
  logic [5:0]    tgt_reg,    tgt_next;
  logic [5:0]    tap_reg,    tap_next;
  logic [6:0]    step_reg,   step_next;
  logic          dir_reg,    dir_next;
  logic          err_reg,    err_next;
  logic [SW-1:0] settle_reg, settle_next;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg  <= ST_IDLE;
      op_reg     <= 2'b00;
      addr_reg   <= 5'd0;
      tgt_reg    <= 6'd0;
      tap_reg    <= 6'd0;
      step_reg   <= 7'd0;
      dir_reg    <= 1'b0;
      err_reg    <= 1'b0;
      settle_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      addr_reg   <= addr_next;
      tgt_reg    <= tgt_next;
      tap_reg    <= tap_next;
      step_reg   <= step_next;
      dir_reg    <= dir_next;
      err_reg    <= err_next;
      settle_reg <= settle_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    addr_next   = addr_reg;
    tgt_next    = tgt_reg;
    tap_next    = tap_reg;
    step_next   = step_reg;
    dir_next    = dir_reg;
    err_next    = err_reg;
    settle_next = settle_reg;

    case (state_reg)
      ST_IDLE: begin
        if (CMD_VALID) begin
          op_next   = CMD_OP;
          addr_next = CMD_ADDR;
          tgt_next  = CMD_TAP;
          tap_next  = 6'd0;      // out-of-range commands report tap 0
          step_next = 7'd0;
          dir_next  = 1'b0;
          err_next  = 1'b0;
          if ({1'b0, CMD_ADDR} >= NUM_DLY_W) begin
            err_next   = 1'b1;
            state_next = ST_RESP;
          end else begin
            state_next = ST_SELECT;
          end
        end
      end

      // One cycle for the mux output to settle on the new select.
      ST_SELECT: state_next = ST_SAMPLE;

      ST_SAMPLE: begin
        tap_next   = DLY_TAP_VALUE;
        state_next = ST_RESP;
        case (op_reg)
          OP_READ: ;
          // A nonzero step count means the single INC/DEC pulse was issued.
          OP_INC: begin
            if (step_reg == 7'd0) begin
              if (DLY_TAP_VALUE == 6'd63) begin
                err_next = 1'b1;
              end else begin
                dir_next   = 1'b1;
                state_next = ST_PULSE;
              end
            end
          end
          OP_DEC: begin
            if (step_reg == 7'd0) begin
              if (DLY_TAP_VALUE == 6'd0) begin
                err_next = 1'b1;
              end else begin
                dir_next   = 1'b0;
                state_next = ST_PULSE;
              end
            end
          end
          default: begin
            // SET walks one tap per step; a stuck element ends after 64 steps.
            if (DLY_TAP_VALUE != tgt_reg) begin
              if (step_reg == MAX_STEPS) begin
                err_next = 1'b1;
              end else begin
                dir_next   = (tgt_reg > DLY_TAP_VALUE);
                state_next = ST_PULSE;
              end
            end
          end
        endcase
      end

      ST_PULSE: begin
        step_next   = step_reg + 7'd1;
        settle_next = '0;
        state_next  = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_reg == SETTLE_LAST) begin
          state_next = ST_SAMPLE;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      ST_RESP: begin
        if (RSP_READY) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Ready is also gated by reset so nothing is accepted while RST is low.
  assign CMD_READY = RST && (state_reg == ST_IDLE);
  assign RSP_VALID = (state_reg == ST_RESP);
  assign RSP_TAP   = tap_reg;
  assign RSP_ERR   = err_reg;
  assign DLY_ADDR  = addr_reg;
  assign BUSY      = (state_reg != ST_IDLE);

  // Adjust pulse is decoded from the registered state, so it drops to zero on
  // the reset edge along with the state.
  generate
    for (genvar gi = 0; gi < NUM_DLY; gi++) begin : g_adj
      assign DLY_ADJ[gi]    = (state_reg == ST_PULSE) && (addr_reg == 5'(gi));
      assign DLY_INCDEC[gi] = (state_reg == ST_PULSE) && (addr_reg == 5'(gi)) && dir_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dly_tap_controller.sv
// -----------------------------------------------------------------------------
// tb_dly_tap_controller
//
// Scoreboard bench for dly_tap_controller. A model of the delay bank answers
// the tap mux and reacts to adjust pulses. Each accepted command pushes its
// expected outcome (computed from the bank contents with plain arithmetic)
// into a queue; an independent monitor checks pulses and responses.
// -----------------------------------------------------------------------------
module tb_dly_tap_controller;

  localparam int NUM    = 20;
  localparam int SETTLE = 2;
  localparam int STEP   = 2 + SETTLE;
  localparam int BOUND  = 3000;

  logic        CLK;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [4:0]  CMD_ADDR;
  logic [5:0]  CMD_TAP;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [5:0]  RSP_TAP;
  logic        RSP_ERR;
  logic [4:0]  DLY_ADDR;
  logic [5:0]  DLY_TAP_VALUE;
  logic [NUM-1:0] DLY_ADJ;
  logic [NUM-1:0] DLY_INCDEC;
  logic        BUSY;

  dly_tap_controller #(.NUM_DLY(NUM), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ADDR(CMD_ADDR), .CMD_TAP(CMD_TAP),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_TAP(RSP_TAP), .RSP_ERR(RSP_ERR),
    .DLY_ADDR(DLY_ADDR), .DLY_TAP_VALUE(DLY_TAP_VALUE),
    .DLY_ADJ(DLY_ADJ), .DLY_INCDEC(DLY_INCDEC), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- delay bank model ----------------
  logic [5:0] elem [0:31];
  bit         stuck [0:31];
  logic       wr_en = 1'b0;
  int         wr_idx = 0;
  logic [5:0] wr_val = 6'd0;

  assign DLY_TAP_VALUE = elem[DLY_ADDR];

  always @(posedge CLK) begin
    if (wr_en) elem[wr_idx] <= wr_val;
    for (int i = 0; i < NUM; i++) begin
      if (DLY_ADJ[i] && !stuck[i]) begin
        if (DLY_INCDEC[i]) elem[i] <= (elem[i] == 6'd63) ? 6'd63 : elem[i] + 6'd1;
        else               elem[i] <= (elem[i] == 6'd0)  ? 6'd0  : elem[i] - 6'd1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int op; int addr; int tap; int err; int pulses; int dir; int lat; int e; int hold;
  } exp_t;

  exp_t q[$];
  int   hs_cyc     = 0;
  int   pulse_cnt  = 0;
  int   last_pulse = 0;

  // Expected outcome from the bank contents at accept time.
  function automatic exp_t predict(input int op, input int addr, input int tgt, input int hold);
    exp_t r;
    int v;
    r.op = op; r.addr = addr; r.hold = hold; r.e = 0;
    r.tap = 0; r.err = 0; r.pulses = 0; r.dir = 0; r.lat = 3;
    if (addr >= NUM) begin
      r.err = 1;
      r.lat = 1;
      return r;
    end
    v = int'(elem[addr]);
    case (op)
      0: r.tap = v;
      1: begin
        if (v == 63) begin r.err = 1; r.tap = 63; end
        else begin
          r.pulses = 1; r.dir = 1; r.lat = 3 + STEP;
          r.tap = stuck[addr] ? v : v + 1;
        end
      end
      2: begin
        if (v == 0) begin r.err = 1; r.tap = 0; end
        else begin
          r.pulses = 1; r.dir = 0; r.lat = 3 + STEP;
          r.tap = stuck[addr] ? v : v - 1;
        end
      end
      default: begin
        r.tap = v;
        if (v != tgt) begin
          r.dir = (tgt > v) ? 1 : 0;
          if (stuck[addr]) begin
            r.pulses = 64; r.err = 1;
          end else begin
            r.pulses = (tgt > v) ? tgt - v : v - tgt;
            r.tap = tgt;
          end
          r.lat = 3 + r.pulses * STEP;
        end
      end
    endcase
    return r;
  endfunction

  task automatic check_pulse();
    logic [NUM-1:0] exp_adj;
    if (DLY_ADJ != '0 || DLY_INCDEC != '0) begin
      if (q.size() == 0) begin
        chk("stray_pulse", int'(DLY_ADJ), 0);
      end else begin
        exp_adj = NUM'(1) << q[0].addr;
        chk("adj_onehot", int'(DLY_ADJ), int'(exp_adj));
        chk("incdec", int'(DLY_INCDEC), (q[0].dir != 0) ? int'(exp_adj) : 0);
        if (pulse_cnt > 0) chk("pulse_spacing", cyc - last_pulse, STEP);
        last_pulse = cyc;
        pulse_cnt++;
      end
    end
  endtask

  // Monitor: owns RSP_READY, pops the queue, checks pulses and responses.
  initial begin : monitor
    exp_t e;
    int   snap_tap, snap_err;
    RSP_READY = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        q.delete();
        pulse_cnt = 0;
        RSP_READY = 1'b0;
      end else begin
        check_pulse();
        if (RSP_VALID) begin
          if (q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
            RSP_READY = 1'b1;
            @(negedge CLK);
            RSP_READY = 1'b0;
          end else begin
            e = q[0];
            chk("rsp_latency", cyc - e.e, e.lat - 1);
            chk("rsp_tap", int'(RSP_TAP), e.tap);
            chk("rsp_err", int'(RSP_ERR), e.err);
            chk("pulse_count", pulse_cnt, e.pulses);
            snap_tap = int'(RSP_TAP);
            snap_err = int'(RSP_ERR);
            for (int h = 0; h < e.hold; h++) begin
              @(negedge CLK);
              chk("hold_valid", int'(RSP_VALID), 1);
              chk("hold_tap", int'(RSP_TAP), snap_tap);
              chk("hold_err", int'(RSP_ERR), snap_err);
              chk("hold_cmd_ready", int'(CMD_READY), 0);
            end
            RSP_READY = 1'b1;
            hs_cyc = cyc + 1;
            @(negedge CLK);
            RSP_READY = 1'b0;
            chk("rsp_drop", int'(RSP_VALID), 0);
            $display("rsp op=%0d addr=%0d tap=%0d err=%0d pulses=%0d hold=%0d",
                     e.op, e.addr, snap_tap, snap_err, pulse_cnt, e.hold);
            q.pop_front();
            pulse_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_elem(input int idx, input int val);
    @(negedge CLK);
    wr_en  = 1'b1;
    wr_idx = idx;
    wr_val = 6'(val);
    @(negedge CLK);
    wr_en  = 1'b0;
  endtask

  task automatic send(input int op, input int addr, input int tgt, input int hold, input bit b2b);
    exp_t e;
    int waited = 0;
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = 2'(op);
    CMD_ADDR  = 5'(addr);
    CMD_TAP   = 6'(tgt);
    while (!CMD_READY && waited < BOUND) begin
      @(negedge CLK);
      waited++;
    end
    if (!CMD_READY) begin
      chk("accept_timeout", 1, 0);
      CMD_VALID = 1'b0;
      return;
    end
    e = predict(op, addr, tgt, hold);
    e.e = cyc + 1;
    q.push_back(e);
    if (b2b) begin
      chk("b2b_waited", (waited > 0) ? 1 : 0, 1);
      chk("b2b_accept", e.e, hs_cyc + 1);
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
    CMD_OP    = 2'($urandom_range(0, 3));
    CMD_ADDR  = 5'($urandom_range(0, 31));
    CMD_TAP   = 6'($urandom_range(0, 63));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || BUSY) && n < BOUND) begin
      @(negedge CLK);
      n++;
    end
    if (n >= BOUND) chk("idle_timeout", 1, 0);
  endtask

  initial begin : stimulus
    int n;
    RST       = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP    = 2'd0;
    CMD_ADDR  = 5'd0;
    CMD_TAP   = 6'd0;
    for (int i = 0; i < 32; i++) stuck[i] = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst_cmd_ready", int'(CMD_READY), 0);
    chk("rst_rsp_valid", int'(RSP_VALID), 0);
    chk("rst_rsp_tap", int'(RSP_TAP), 0);
    chk("rst_rsp_err", int'(RSP_ERR), 0);
    chk("rst_dly_addr", int'(DLY_ADDR), 0);
    chk("rst_dly_adj", int'(DLY_ADJ), 0);
    chk("rst_dly_incdec", int'(DLY_INCDEC), 0);
    chk("rst_busy", int'(BUSY), 0);

    for (int i = 0; i < 32; i++) set_elem(i, int'($urandom_range(0, 63)));
    set_elem(7, 'h15);
    set_elem(3, 62);
    set_elem(0, 0);
    set_elem(19, 10);

    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", int'(CMD_READY), 1);

    // Directed cases
    send(0, 7, 0, 0, 0);     // READ 0x15
    send(1, 3, 0, 0, 0);     // INC 62 -> 63
    send(1, 3, 0, 0, 0);     // INC at 63 -> ERR
    send(2, 0, 0, 0, 0);     // DEC at 0 -> ERR
    send(3, 19, 40, 0, 0);   // SET 10 -> 40
    send(3, 19, 5, 0, 0);    // SET 40 -> 5
    send(0, 20, 0, 0, 0);    // bad address
    send(1, 31, 0, 0, 0);    // bad address
    wait_idle();

    stuck[12] = 1'b1;
    set_elem(12, 10);
    send(3, 12, 10, 0, 0);   // already there, no pulses
    send(3, 12, 20, 0, 0);   // stuck: 64 pulses then ERR
    wait_idle();
    stuck[12] = 1'b0;

    // Backpressure, then a command waiting on the handshake
    send(0, 7, 0, 10, 0);
    send(2, 3, 0, 0, 1);
    wait_idle();

    // Reset in the middle of a SET
    set_elem(5, 0);
    send(3, 5, 60, 0, 0);
    n = 0;
    while (DLY_ADJ == '0 && n < BOUND) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_saw_pulse", (DLY_ADJ != '0) ? 1 : 0, 1);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_dly_adj", int'(DLY_ADJ), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_rsp_valid", int'(RSP_VALID), 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    send(0, 5, 0, 0, 0);
    wait_idle();

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        case ($urandom_range(0, 2))
          0:       set_elem(int'($urandom_range(0, NUM - 1)), 0);
          1:       set_elem(int'($urandom_range(0, NUM - 1)), 63);
          default: set_elem(int'($urandom_range(0, NUM - 1)), int'($urandom_range(0, 63)));
        endcase
      end
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 23)),
           int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 0);
    end
    wait_idle();
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
